// File: rtl/tag_req_queue.sv
// Tag request queue: buffers host requests in order, issues one AXI AR per
// entry for its tag line, and pops the head when the comparator consumes it.
module tag_req_queue #(
  parameter int              DEPTH          = 8,
  parameter int              AEMPTY_TH      = 1,
  parameter int              INDEX_BIT_SIZE = 8,
  parameter int              ADDR_W         = 64,
  parameter logic [ADDR_W-1:0] TAG_BASE     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [80:0]                req_data_i,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  output logic [ADDR_W-1:0]          araddr_o,
  input  logic                       fifo_pop_i,
  output logic                       fifo_aempty_o,
  output logic [80:0]                fifo_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_IDLE, S_ADDR} state_t;

  state_t          state;
  logic [80:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   iss_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            push;
  logic            pop_ok;
  logic [ADDR_W-1:0] ar_next;

  assign count         = wr_ptr - rd_ptr;
  assign count_o       = count;
  assign req_ready_o   = count < PW'(DEPTH);
  assign fifo_aempty_o = count <= PW'(AEMPTY_TH);
  assign push          = req_valid_i & req_ready_o;
  assign pop_ok        = fifo_pop_i & (rd_ptr != iss_ptr);

  assign fifo_data_o = (count == '0) ? '0
                     : mem[rd_ptr[AW-1:0]];

  assign ar_next = TAG_BASE
    + (ADDR_W'(mem[iss_ptr[AW-1:0]][INDEX_BIT_SIZE-1:0]) << 3);

  // Entry storage; contents are only observed while the slot is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req_data_i;
  end

  // Write and read pointers; a pop only retires entries already issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error when the comparator pops something with no AR sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_o <= 1'b0;
    else if (fifo_pop_i && !pop_ok) err_o <= 1'b1;
  end

  // AR issue FSM: one outstanding address phase at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      iss_ptr   <= '0;
      arvalid_o <= 1'b0;
      araddr_o  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (iss_ptr != wr_ptr) begin
            araddr_o  <= ar_next;
            arvalid_o <= 1'b1;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready_i) begin
            iss_ptr   <= iss_ptr + 1'b1;
            arvalid_o <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_req_queue.sv
// Directed bench for tag_req_queue: reset, single read, fill, full push+pop,
// early pop error, asynchronous mid-run reset and pointer wrap ordering.
module tb_tag_req_queue;

  localparam logic [63:0] TB_BASE = 64'h0000_0000_1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [80:0] req_data_i;
  logic        arvalid_o;
  logic        arready_i;
  logic [63:0] araddr_o;
  logic        fifo_pop_i;
  logic        fifo_aempty_o;
  logic [80:0] fifo_data_o;
  logic [3:0]  count_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  tag_req_queue #(
    .DEPTH(8), .AEMPTY_TH(1), .INDEX_BIT_SIZE(8),
    .ADDR_W(64), .TAG_BASE(TB_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .fifo_pop_i(fifo_pop_i), .fifo_aempty_o(fifo_aempty_o),
    .fifo_data_o(fifo_data_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ar_of(input logic [80:0] d);
    return TB_BASE + {53'b0, d[7:0], 3'b0};
  endfunction

  function automatic logic [80:0] mk(input int i);
    logic [7:0] ix;
    ix = 8'(i * 7 + 3);
    return {1'(i), 16'(i + 256), 48'hCAFE_0000_0000, 8'(i), ix};
  endfunction

  task automatic test_reset;
    rst = 1'b1; req_valid_i = 0; arready_i = 0;
    fifo_pop_i = 0; req_data_i = '0;
    #1;
    checks++; if (arvalid_o !== 1'b0) begin errors++;
      $display("FAIL rst_arvalid got=%b exp=0", arvalid_o); end
    checks++; if (count_o !== 4'd0) begin errors++;
      $display("FAIL rst_count got=%0d exp=0", count_o); end
    checks++; if (fifo_aempty_o !== 1'b1) begin errors++;
      $display("FAIL rst_aempty got=%b exp=1", fifo_aempty_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++;
      $display("FAIL rst_ready got=%b exp=1", req_ready_o); end
    checks++; if (err_o !== 1'b0) begin errors++;
      $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if (fifo_data_o !== 81'd0) begin errors++;
      $display("FAIL rst_data got=%h exp=0", fifo_data_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    logic [80:0] d;
    d = {1'b0, 16'h5, 64'h1234_5678_9ABC_DE42};
    @(negedge clk);
    req_valid_i = 1; req_data_i = d; arready_i = 1;
    @(negedge clk);
    req_valid_i = 0;
    checks++; if (count_o !== 4'd1) begin errors++;
      $display("FAIL single_count got=%0d exp=1", count_o); end
    checks++; if (arvalid_o !== 1'b0) begin errors++;
      $display("FAIL single_ar_early got=%b exp=0", arvalid_o); end
    checks++; if (fifo_data_o !== d) begin errors++;
      $display("FAIL single_data got=%h exp=%h", fifo_data_o, d); end
    @(negedge clk);
    checks++; if (arvalid_o !== 1'b1) begin errors++;
      $display("FAIL single_arvalid got=%b exp=1", arvalid_o); end
    checks++; if (araddr_o !== TB_BASE + 64'h210) begin errors++;
      $display("FAIL single_araddr got=%h exp=%h", araddr_o,
               TB_BASE + 64'h210); end
    @(negedge clk);
    arready_i = 0;
    checks++; if (arvalid_o !== 1'b0) begin errors++;
      $display("FAIL single_ar_drop got=%b exp=0", arvalid_o); end
    fifo_pop_i = 1;
    @(negedge clk);
    fifo_pop_i = 0;
    checks++; if (count_o !== 4'd0) begin errors++;
      $display("FAIL single_pop_count got=%0d exp=0", count_o); end
    checks++; if (fifo_data_o !== 81'd0) begin errors++;
      $display("FAIL single_pop_data got=%h exp=0", fifo_data_o); end
    checks++; if (err_o !== 1'b0) begin errors++;
      $display("FAIL single_err got=%b exp=0", err_o); end
  endtask

  task automatic test_fill;
    arready_i = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (arvalid_o !== 1'b1 || araddr_o !== ar_of(mk(10))) begin
          errors++;
          $display("FAIL fill_ar_hold i=%0d got=%b/%h exp=1/%h", i,
                   arvalid_o, araddr_o, ar_of(mk(10)));
        end
      end
      if (i == 8) begin
        checks++; if (req_ready_o !== 1'b0) begin errors++;
          $display("FAIL fill_ready got=%b exp=0", req_ready_o); end
      end
      req_valid_i = 1; req_data_i = mk(10 + i);
    end
    @(negedge clk);
    req_valid_i = 0;
    checks++; if (count_o !== 4'd8) begin errors++;
      $display("FAIL fill_count got=%0d exp=8", count_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++;
      $display("FAIL fill_ready2 got=%b exp=0", req_ready_o); end
    checks++; if (fifo_data_o !== mk(10)) begin errors++;
      $display("FAIL fill_head got=%h exp=%h", fifo_data_o, mk(10)); end
    checks++;
    if (arvalid_o !== 1'b1 || araddr_o !== ar_of(mk(10))) begin
      errors++;
      $display("FAIL fill_ar_end got=%b/%h exp=1/%h",
               arvalid_o, araddr_o, ar_of(mk(10)));
    end
  endtask

  task automatic test_full_push_pop;
    @(negedge clk);
    arready_i = 1;
    @(negedge clk);
    arready_i = 0;
    checks++; if (arvalid_o !== 1'b0 || count_o !== 4'd8) begin
      errors++;
      $display("FAIL full_ar_done got=%b/%0d exp=0/8", arvalid_o, count_o);
    end
    req_valid_i = 1; req_data_i = mk(99); fifo_pop_i = 1;
    @(negedge clk);
    req_valid_i = 0; fifo_pop_i = 0;
    checks++; if (count_o !== 4'd7) begin errors++;
      $display("FAIL full_pp_count got=%0d exp=7", count_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++;
      $display("FAIL full_pp_ready got=%b exp=1", req_ready_o); end
    checks++; if (fifo_data_o !== mk(11)) begin errors++;
      $display("FAIL full_pp_head got=%h exp=%h", fifo_data_o, mk(11)); end
    checks++;
    if (arvalid_o !== 1'b1 || araddr_o !== ar_of(mk(11))) begin
      errors++;
      $display("FAIL full_pp_ar got=%b/%h exp=1/%h",
               arvalid_o, araddr_o, ar_of(mk(11)));
    end
    @(negedge clk);
    checks++; if (count_o !== 4'd7) begin errors++;
      $display("FAIL full_pp_drop got=%0d exp=7", count_o); end
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1; req_valid_i = 0; arready_i = 0; fifo_pop_i = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_early_pop;
    @(negedge clk);
    req_valid_i = 1; req_data_i = mk(40); arready_i = 0;
    @(negedge clk);
    req_valid_i = 0; fifo_pop_i = 1;
    @(negedge clk);
    fifo_pop_i = 0;
    checks++; if (err_o !== 1'b1) begin errors++;
      $display("FAIL early_err got=%b exp=1", err_o); end
    checks++; if (count_o !== 4'd1) begin errors++;
      $display("FAIL early_count got=%0d exp=1", count_o); end
    checks++; if (fifo_data_o !== mk(40)) begin errors++;
      $display("FAIL early_data got=%h exp=%h", fifo_data_o, mk(40)); end
    arready_i = 1;
    @(negedge clk);
    arready_i = 0; fifo_pop_i = 1;
    @(negedge clk);
    fifo_pop_i = 0;
    checks++; if (count_o !== 4'd0 || err_o !== 1'b1) begin errors++;
      $display("FAIL early_after got=%0d/%b exp=0/1", count_o, err_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid_i = 1; req_data_i = mk(50);
    @(negedge clk);
    req_data_i = mk(51);
    @(negedge clk);
    req_valid_i = 0;
    checks++; if (arvalid_o !== 1'b1 || count_o !== 4'd2) begin errors++;
      $display("FAIL mid_pre got=%b/%0d exp=1/2", arvalid_o, count_o); end
    #2 rst = 1;
    #1;
    checks++; if (arvalid_o !== 1'b0 || araddr_o !== 64'd0) begin
      errors++;
      $display("FAIL mid_ar got=%b/%h exp=0/0", arvalid_o, araddr_o);
    end
    checks++; if (count_o !== 4'd0 || fifo_aempty_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_cnt got=%0d/%b exp=0/1", count_o, fifo_aempty_o);
    end
    checks++; if (req_ready_o !== 1'b1 || err_o !== 1'b0) begin errors++;
      $display("FAIL mid_rdy_err got=%b/%b exp=1/0", req_ready_o, err_o); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_wrap;
    int pushed, issued, popped, cnt, cyc;
    logic do_push, do_pop, ar;
    logic [80:0] exp_d;
    pushed = 0; issued = 0; popped = 0; cyc = 0;
    while (popped < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      cnt = pushed - popped;
      exp_d = (cnt == 0) ? 81'd0 : mk(200 + popped);
      checks++; if (count_o !== 4'(cnt)) begin errors++;
        $display("FAIL wrap_count got=%0d exp=%0d", count_o, cnt); end
      checks++; if (fifo_data_o !== exp_d) begin errors++;
        $display("FAIL wrap_data got=%h exp=%h", fifo_data_o, exp_d); end
      checks++; if (fifo_aempty_o !== (cnt <= 1)) begin errors++;
        $display("FAIL wrap_aempty got=%b cnt=%0d", fifo_aempty_o, cnt); end
      if (arvalid_o) begin
        checks++;
        if (issued >= pushed ||
            araddr_o !== ar_of(mk(200 + issued))) begin
          errors++;
          $display("FAIL wrap_araddr got=%h exp=%h", araddr_o,
                   ar_of(mk(200 + issued)));
        end
      end
      do_push = (pushed < 20) && (cnt < 8) && ($urandom_range(0, 3) != 0);
      ar      = 1'($urandom_range(0, 1));
      do_pop  = (issued > popped) && ($urandom_range(0, 2) != 0);
      req_valid_i = do_push;
      req_data_i  = do_push ? mk(200 + pushed) : '0;
      arready_i   = ar;
      fifo_pop_i  = do_pop;
      if (arvalid_o && ar) issued++;
      if (do_push) pushed++;
      if (do_pop) popped++;
    end
    @(negedge clk);
    req_valid_i = 0; arready_i = 0; fifo_pop_i = 0;
    checks++; if (popped != 20) begin errors++;
      $display("FAIL wrap_timeout popped=%0d exp=20", popped); end
    checks++; if (err_o !== 1'b0 || count_o !== 4'd0) begin errors++;
      $display("FAIL wrap_end got=%b/%0d exp=0/0", err_o, count_o); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_fill;
    test_full_push_pop;
    pulse_reset;
    test_early_pop;
    test_reset_mid;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
